// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants.
// Holds the fetch FSM encoding and the IF/ID bundle.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;
    localparam logic [31:0] ROM_LAST_DEFAULT = 32'hBFC00FFF;
    localparam logic [31:0] NOP_INSTR        = 32'h00000013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_RESET = '{
        pc:    32'h0,
        pc4:   32'h0,
        instr: NOP_INSTR,
        valid: 1'b0
    };

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load enable and flush.
// Flush wins over load and only kills valid/instr.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_load,
    input  logic   i_flush,
    input  if_id_t i_d,
    output if_id_t o_q
);

    if_id_t r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= IF_ID_RESET;
        end else if (i_flush) begin
            r_q.valid <= 1'b0;
            r_q.instr <= NOP_INSTR;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, BOOT/RUN/HALT control, fetch counter.
// The ROM answers combinationally, so IF/ID holds the result one edge later.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] ROM_LAST = ROM_LAST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc_plus4_o,
    output logic [31:0] if_instr_o,
    output logic        if_valid_o,
    output logic        fetch_fault_o,
    output logic [31:0] fetch_count_o
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic         r_fault;
    logic [31:0]  r_count;
    logic         w_load;
    logic         w_flush;
    logic         w_fault_set;
    logic         w_oob;
    if_id_t       w_d;
    if_id_t       w_q;

    // 33-bit compare so pc+3 cannot wrap past the window end
    assign w_oob = (r_pc < RESET_PC) ||
                   (({1'b0, r_pc} + 33'd3) > {1'b0, ROM_LAST});

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_flush      = 1'b0;
        w_fault_set  = 1'b0;
        unique case (r_state)
            BOOT: begin
                w_state_next = RUN;
            end
            RUN: begin
                if (redirect_i) begin
                    w_pc_next = {redirect_target_i[31:2], 2'b00};
                    w_flush   = 1'b1;
                    if (redirect_target_i[1:0] != 2'b00) begin
                        w_fault_set  = 1'b1;
                        w_state_next = HALT;
                    end
                end else if (w_oob) begin
                    w_flush      = 1'b1;
                    w_fault_set  = 1'b1;
                    w_state_next = HALT;
                end else if (!stall_i) begin
                    w_load    = 1'b1;
                    w_pc_next = r_pc + 32'd4;
                end
            end
            HALT: begin
                w_state_next = HALT;
            end
            default: begin
                w_state_next = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
            r_count <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end
            if (w_load) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign w_d = '{
        pc:    r_pc,
        pc4:   r_pc + 32'd4,
        instr: instr_rdata_i,
        valid: 1'b1
    };

    if_id_reg u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_d     (w_d),
        .o_q     (w_q)
    );

    assign instr_addr_o  = r_pc;
    assign if_pc_o       = w_q.pc;
    assign if_pc_plus4_o = w_q.pc4;
    assign if_instr_o    = w_q.instr;
    assign if_valid_o    = w_q.valid;
    assign fetch_fault_o = r_fault;
    assign fetch_count_o = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random
// stall/redirect/reset traffic against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'hBFC00000;
    localparam logic [31:0] RLAST  = 32'hBFC00FFF;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic [31:0] instr_addr_o;
    logic [31:0] instr_rdata_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc_plus4_o;
    logic [31:0] if_instr_o;
    logic        if_valid_o;
    logic        fetch_fault_o;
    logic [31:0] fetch_count_o;

    int n_total;
    int n_bad;

    // behavioural model
    logic [31:0] m_pc;
    logic        m_boot;
    logic        m_halt;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
    logic        e_v;
    logic        m_fault;
    logic [31:0] m_cnt;

    fetch_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .instr_addr_o      (instr_addr_o),
        .instr_rdata_i     (instr_rdata_i),
        .if_pc_o           (if_pc_o),
        .if_pc_plus4_o     (if_pc_plus4_o),
        .if_instr_o        (if_instr_o),
        .if_valid_o        (if_valid_o),
        .fetch_fault_o     (fetch_fault_o),
        .fetch_count_o     (fetch_count_o)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'hBFC00000) return 32'h00500093;
        if (a == 32'hBFC00004) return 32'h00A00113;
        return {a[15:0], ~a[15:0]} ^ 32'h13570000;
    endfunction

    assign instr_rdata_i = rom_word(instr_addr_o);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_boot  = 1'b1;
        m_halt  = 1'b0;
        e_pc    = 32'h0;
        e_pc4   = 32'h0;
        e_instr = NOP;
        e_v     = 1'b0;
        m_fault = 1'b0;
        m_cnt   = 32'h0;
    endtask

    task automatic model_step(input logic st, input logic rd,
                              input logic [31:0] tg);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halt) begin
        end else if (rd) begin
            m_pc    = tg & 32'hFFFFFFFC;
            e_v     = 1'b0;
            e_instr = NOP;
            if (tg % 4 != 0) begin
                m_fault = 1'b1;
                m_halt  = 1'b1;
            end
        end else if (m_pc < RST_PC || m_pc > RLAST - 3) begin
            e_v     = 1'b0;
            e_instr = NOP;
            m_fault = 1'b1;
            m_halt  = 1'b1;
        end else if (!st) begin
            e_pc    = m_pc;
            e_pc4   = m_pc + 4;
            e_instr = rom_word(m_pc);
            e_v     = 1'b1;
            m_cnt   = m_cnt + 1;
            m_pc    = m_pc + 4;
        end
    endtask

    task automatic check_all();
        chk("addr",  instr_addr_o,          m_pc);
        chk("pc",    if_pc_o,               e_pc);
        chk("pc4",   if_pc_plus4_o,         e_pc4);
        chk("instr", if_instr_o,            e_instr);
        chk("valid", {31'b0, if_valid_o},   {31'b0, e_v});
        chk("fault", {31'b0, fetch_fault_o},{31'b0, m_fault});
        chk("count", fetch_count_o,         m_cnt);
    endtask

    task automatic step(input logic st, input logic rd,
                        input logic [31:0] tg);
        stall_i           = st;
        redirect_i        = rd;
        redirect_target_i = tg;
        @(posedge clk);
        model_step(st, rd, tg);
        #1;
        check_all();
    endtask

    // asynchronous pulse in the middle of a cycle
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_addr",  instr_addr_o,           RST_PC);
        chk("rst_pc",    if_pc_o,                32'h0);
        chk("rst_pc4",   if_pc_plus4_o,          32'h0);
        chk("rst_instr", if_instr_o,             NOP);
        chk("rst_valid", {31'b0, if_valid_o},    32'h0);
        chk("rst_fault", {31'b0, fetch_fault_o}, 32'h0);
        chk("rst_count", fetch_count_o,          32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] tg;
        int          r;
        n_total           = 0;
        n_bad             = 0;
        rst_n             = 1'b0;
        stall_i           = 1'b0;
        redirect_i        = 1'b0;
        redirect_target_i = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // boot bubble and first two words
        step(1'b0, 1'b0, 32'h0);
        chk("boot_bubble", {31'b0, if_valid_o}, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("w0_pc", if_pc_o, 32'hBFC00000);
        chk("w0_in", if_instr_o, 32'h00500093);
        step(1'b0, 1'b0, 32'h0);
        chk("w1_pc", if_pc_o, 32'hBFC00004);
        chk("w1_in", if_instr_o, 32'h00A00113);
        chk("w1_cnt", fetch_count_o, 32'd2);

        // stall holds everything
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0);
            chk("stall_addr", instr_addr_o, 32'hBFC00008);
            chk("stall_cnt", fetch_count_o, 32'd2);
        end
        step(1'b0, 1'b0, 32'h0);
        chk("resume_pc", if_pc_o, 32'hBFC00008);

        // redirect overrides stall
        step(1'b1, 1'b1, 32'hBFC00040);
        chk("rd_valid", {31'b0, if_valid_o}, 32'h0);
        chk("rd_instr", if_instr_o, NOP);
        chk("rd_addr", instr_addr_o, 32'hBFC00040);
        step(1'b0, 1'b0, 32'h0);
        chk("rd_word", if_instr_o, rom_word(32'hBFC00040));

        // reset mid-run at count 7
        repeat (3) step(1'b0, 1'b0, 32'h0);
        chk("cnt7", fetch_count_o, 32'd7);
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        chk("reboot_bubble", {31'b0, if_valid_o}, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("reboot_pc", if_pc_o, 32'hBFC00000);

        // misaligned redirect halts
        step(1'b0, 1'b1, 32'hBFC00042);
        chk("mis_fault", {31'b0, fetch_fault_o}, 32'h1);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 32'hBFC00040);
            chk("halt_valid", {31'b0, if_valid_o}, 32'h0);
        end

        // run off the end of the ROM window
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hBFC00FF8);
        repeat (3) step(1'b0, 1'b0, 32'h0);
        chk("end_fault", {31'b0, fetch_fault_o}, 32'h1);
        chk("end_last", if_pc_o, 32'hBFC00FFC);
        repeat (2) step(1'b0, 1'b0, 32'h0);
        chk("end_addr", instr_addr_o, 32'hBFC01000);
        chk("end_valid", {31'b0, if_valid_o}, 32'h0);

        // random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end
            r = $urandom_range(0, 99);
            if (r < 90)
                tg = RST_PC + ($urandom_range(0, 1023) << 2);
            else if (r < 95)
                tg = RST_PC + ($urandom_range(0, 1023) << 2)
                     + $urandom_range(1, 3);
            else if (r < 98)
                tg = 32'hBFC00FF0 + ($urandom_range(0, 7) << 2);
            else
                tg = 32'hBFBFFFF0;
            step(($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0), tg);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
